dbus_xbar: RTL and testbench

Parametrised successor of the two-slot data-bus decoder. It sits between the core's data port and NS memory-mapped slaves (RAM, IO, timers, …). Each access is decoded by the top SEL_W address bits and run through a registered request/acknowledge handshake, so slaves may insert wait states. Unmapped regions and unresponsive slaves are reported to the master as a bus error instead of returning silent zeros.

---
 rtl/dbus_pkg.sv | 14 +
 rtl/dbus_wdt.sv | 30 +++
 rtl/dbus_xbar.sv | 127 ++++++++++++
 tb/tb_dbus_xbar.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus crossbar: FSM encoding and the
// read-data value returned alongside a bus error.
package dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MAX_DW = 64;
    localparam logic [MAX_DW-1:0] ERR_RDATA = '0;

endpackage

// File: rtl/dbus_wdt.sv
// Wait-state watchdog: counts cycles spent waiting for a slave ack and
// flags the last permitted cycle so the FSM can bail out on that edge.
module dbus_wdt #(
    parameter int TO_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TO_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of completed wait cycles, so it equals TO_CYC-1
    // during the TO_CYC-th cycle; saturating keeps it from wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/dbus_xbar.sv
// Data-bus crossbar: decodes the master address into one of NS slaves and
// runs a registered req/ack handshake with timeout and unmapped-region errors.
module dbus_xbar
    import dbus_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 16,
    parameter int SEL_W  = 3,
    parameter int NS     = 4,
    parameter int TO_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_req,
    input  logic                m_we,
    input  logic [AW-1:0]       m_addr,
    input  logic [DW-1:0]       m_din,
    output logic [DW-1:0]       m_dout,
    output logic                m_ack,
    output logic                m_err,
    output logic [NS-1:0]       s_req,
    output logic                s_we,
    output logic [AW-SEL_W-1:0] s_addr,
    output logic [DW-1:0]       s_din,
    input  logic [NS*DW-1:0]    s_dout,
    input  logic [NS-1:0]       s_ack
);
    localparam int SAW = AW - SEL_W;

    state_t        state, state_nxt;
    logic [NS-1:0] hit;
    logic          mapped;
    logic          ack_hit;
    logic          expired;
    logic [DW-1:0] rd_sel;

    // Region decode; regions at or above NS leave hit all-zero.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NS; i++)
            hit[i] = (m_addr[AW-1 -: SEL_W] == SEL_W'(i));
    end
    assign mapped = |hit;

    // s_req is the latched one-hot select, so it doubles as the ack/data mask.
    assign ack_hit = (state == WAIT) && |(s_ack & s_req);

    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NS; i++)
            rd_sel = rd_sel | (s_dout[i*DW +: DW] & {DW{s_req[i]}});
    end

    dbus_wdt #(.TO_CYC(TO_CYC)) u_wdt (
        .clk     (clk),
        .rst     (rst),
        .clr     (state != WAIT),
        .en      (state == WAIT),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (m_req) state_nxt = mapped ? WAIT : RESP;
            WAIT: if (ack_hit || expired) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_req  <= '0;
            s_we   <= 1'b0;
            s_addr <= '0;
            s_din  <= '0;
            m_ack  <= 1'b0;
            m_err  <= 1'b0;
            m_dout <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (m_req) begin
                        s_we   <= m_we;
                        s_addr <= m_addr[SAW-1:0];
                        s_din  <= m_din;
                        if (mapped) begin
                            s_req <= hit;
                        end else begin
                            m_ack  <= 1'b1;
                            m_err  <= 1'b1;
                            m_dout <= ERR_RDATA[DW-1:0];
                        end
                    end
                end
                WAIT: begin
                    // Ack is tested first so it wins over a same-cycle timeout.
                    if (ack_hit) begin
                        s_req  <= '0;
                        m_ack  <= 1'b1;
                        m_err  <= 1'b0;
                        m_dout <= s_we ? '0 : rd_sel;
                    end else if (expired) begin
                        s_req  <= '0;
                        m_ack  <= 1'b1;
                        m_err  <= 1'b1;
                        m_dout <= ERR_RDATA[DW-1:0];
                    end
                end
                RESP: begin
                    m_ack <= 1'b0;
                    m_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_xbar.sv
// Randomized + directed bench for dbus_xbar against a latency/response model.
module tb_dbus_xbar;
    localparam int DW = 16, AW = 16, SEL_W = 3, NS = 4, TO_CYC = 15;

    logic                clk, rst;
    logic                m_req, m_we;
    logic [AW-1:0]       m_addr;
    logic [DW-1:0]       m_din, m_dout;
    logic                m_ack, m_err;
    logic [NS-1:0]       s_req;
    logic                s_we;
    logic [AW-SEL_W-1:0] s_addr;
    logic [DW-1:0]       s_din;
    logic [NS*DW-1:0]    s_dout;
    logic [NS-1:0]       s_ack;

    int n_chk = 0, n_fail = 0;

    dbus_xbar #(.DW(DW), .AW(AW), .SEL_W(SEL_W), .NS(NS), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_din(m_din), .m_dout(m_dout), .m_ack(m_ack), .m_err(m_err),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_din(s_din),
        .s_dout(s_dout), .s_ack(s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One master access. delay = wait states the target slave inserts
    // (it acks in its (delay+1)-th s_req cycle).
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] din,
                          input logic [15:0] rdata, input int delay,
                          input bit stray_rand, input bit stray1_c1);
        int          region, exp_lat, exp_sreq, lat, sreq_cyc, seen;
        bit          mapped, bad_sreq;
        logic        exp_err, got_err;
        logic [15:0] exp_dout, got_dout;
        logic [NS-1:0] exp_oh;

        region = int'(addr[15:13]);
        mapped = region < NS;
        exp_oh = mapped ? NS'(1 << region) : '0;
        if (!mapped) begin
            exp_lat = 1; exp_err = 1'b1; exp_dout = 16'h0; exp_sreq = 0;
        end else if (delay < TO_CYC) begin
            exp_lat = delay + 2; exp_err = 1'b0; exp_dout = we ? 16'h0 : rdata; exp_sreq = delay + 1;
        end else begin
            exp_lat = TO_CYC + 1; exp_err = 1'b1; exp_dout = 16'h0; exp_sreq = TO_CYC;
        end

        m_we = we; m_addr = addr; m_din = din; m_req = 1'b1;
        lat = 0; sreq_cyc = 0; seen = 0; bad_sreq = 0; got_err = 1'b0; got_dout = '0;
        @(posedge clk);
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            #1;
            if (s_req != '0) begin
                if (s_req == exp_oh) sreq_cyc++;
                else bad_sreq = 1;
            end
            if (c == 1 && mapped) begin
                chk("s_addr", 32'(s_addr), 32'(addr[12:0]));
                chk("s_din", 32'(s_din), 32'(din));
                chk("s_we", 32'(s_we), 32'(we));
            end
            for (int i = 0; i < NS; i++) s_dout[i*DW +: DW] = DW'($urandom);
            s_ack = stray_rand ? (NS'($urandom) & ~exp_oh) : '0;
            if (stray1_c1 && c == 1) s_ack[1] = 1'b1;
            if ((s_req & exp_oh) != '0) begin
                seen++;
                if (seen == delay + 1) begin
                    s_ack = s_ack | exp_oh;
                    s_dout[region*DW +: DW] = rdata;
                end
            end
            if (m_ack) begin
                lat = c; got_err = m_err; got_dout = m_dout; m_req = 1'b0;
            end
            @(posedge clk);
        end
        m_req = 1'b0;
        #1;
        s_ack = '0;
        chk("lat", 32'(lat), 32'(exp_lat));
        chk("err", 32'(got_err), 32'(exp_err));
        chk("dout", 32'(got_dout), 32'(exp_dout));
        chk("sreq_cyc", 32'(sreq_cyc), 32'(exp_sreq));
        chk("sreq_bad", 32'(bad_sreq), 32'd0);
        chk("ack_pulse", 32'(m_ack), 32'd0);
    endtask

    initial begin
        bit ack_seen;
        rst = 1'b0; m_req = 0; m_we = 0; m_addr = '0; m_din = '0; s_dout = '0; s_ack = '0;
        #12;
        chk("rst_sreq", 32'(s_req), 32'd0);
        chk("rst_ack", 32'(m_ack), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_dout", 32'(m_dout), 32'd0);
        chk("rst_saddr", 32'(s_addr), 32'd0);
        chk("rst_sdin_we", 32'({s_din, s_we}), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        access(1'b1, 16'h2004, 16'h1234, 16'h0000, 0, 0, 0);
        access(1'b0, 16'h4010, 16'h0000, 16'hBEEF, 3, 0, 0);
        access(1'b0, 16'hA000, 16'h0000, 16'h5555, 0, 0, 0);
        access(1'b0, 16'h6000, 16'h0000, 16'h1111, 1000, 0, 0);
        access(1'b0, 16'h6000, 16'h0000, 16'h2222, TO_CYC - 1, 0, 0);
        access(1'b0, 16'h0000, 16'h0000, 16'h3333, 2, 0, 1);

        // Reset in the middle of a WAIT phase
        m_we = 1'b0; m_addr = 16'h6008; m_req = 1'b1;
        @(posedge clk); @(posedge clk); @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("midrst_sreq", 32'(s_req), 32'd0);
        m_req = 1'b0;
        ack_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (m_ack) ack_seen = 1;
        end
        chk("midrst_noack", 32'(ack_seen), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 16'h2020, 16'h0000, 16'hCAFE, 1, 0, 0);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            int d;
            d = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TO_CYC - 2, TO_CYC + 3))
                                            : int'($urandom_range(0, 5));
            access(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), d, 1, 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
